jk_shift_ctrl: RTL
==================

# jk_shift_ctrl

Sequencing controller for the JK-flip-flop shift register. Accepts one command at a time (parallel load, shift left, shift right, rotate) over a valid/ready handshake and drives per-stage `j`/`k` codes into a WIDTH-stage bank of JK flip-flops, reading stage outputs back on `q`. It sits between the register's user logic and the flip-flop bank, so users never hand-build JK codes.

## Interface
- `WIDTH`, 8: number of JK stages controlled; ≥ 2.
- `CNT_W`, 4: width of the shift-count field; max shifts per command = 2^CNT_W − 1.

- `clk`  in  1  rising-edge clock, shared with the flip-flop bank.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 load, 01 shift left, 10 shift right, 11 rotate left.
- `cmd_data`  in  WIDTH  parallel-load value; ignored for other ops.
- `cmd_count`  in  CNT_W  number of shift steps; ignored for load.
- `ser_in`  in  1  serial fill bit for shifts; sampled every SHIFT cycle.
- `q`  in  WIDTH  current stage outputs fed back from the flip-flop bank.
- `j`, `k`  out  WIDTH each  per-stage JK code.
- `ser_out`  out  1  bit leaving the register in the current SHIFT cycle.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Stage code per bit i, `{j[i],k[i]}`: 00 hold, 01 set (next q=1), 10 clear (next q=0), 11 toggle. Controller emits only 00, 01, 10 (11 is never driven).
- To make stage i take value v: v=1 → 01, v=0 → 10.
- States: IDLE, LOAD, SHIFT, DONE.
  - IDLE: all codes 00; `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch op, data, count. Op 00 → LOAD; other ops → SHIFT if count ≠ 0, else DONE.
  - LOAD: one cycle; stage i driven to `cmd_data[i]`; → DONE.
  - SHIFT: remaining-count register decrements each cycle; → DONE when it reaches 1.
    - Left: stage i ← q[i−1]; stage 0 ← `ser_in`; `ser_out` = q[WIDTH−1].
    - Right: stage i ← q[i+1]; stage WIDTH−1 ← `ser_in`; `ser_out` = q[0].
    - Rotate: stage i ← q[i−1]; stage 0 ← q[WIDTH−1]; `ser_out` = q[WIDTH−1].
  - DONE: codes 00; `done`=1 for this cycle; → IDLE.
- `j`/`k`/`ser_out` are combinational from state register, latched op and `q`. `busy` = state ∈ {LOAD, SHIFT, DONE}. `cmd_ready` = state == IDLE.
- `ser_out`=0 outside SHIFT.
- Count register is CNT_W bits; no wrap: count = 2^CNT_W − 1 yields exactly that many shifts.
- `cmd_valid` while not ready: ignored, no queueing. Command fields may change after acceptance without effect.

## Timing
- Reset values while `rst` high: state IDLE, `j`=`k`=0, `busy`=0, `done`=0, `ser_out`=0, `cmd_ready`=1. No command is accepted while `rst` is high.
- Reset mid-command: immediate return to IDLE, codes 00 asynchronously, no `done` pulse; stage contents are whatever the bank last latched.
- Accept at edge T. Load: LOAD during cycle T..T+1, `q` updated at edge T+1, `done` high in cycle T+1..T+2, `cmd_ready` high again after edge T+2.
- Shift with count N ≥ 1: N SHIFT cycles, `q` updated at edges T+1..T+N, `done` high in cycle after edge T+N, next accept earliest at edge T+N+2.
- Count 0 shift: `done` in the cycle after accept; stages untouched.
- Back-to-back: a new command may be accepted on the first edge `cmd_ready` is 1.

## Configuration
- `JK_SHIFT_CTRL_ROTATE_EN` defined: op 11 rotates left as above.
- Not defined: rotate logic compiled out; op 11 behaves identically to op 01 (shift left with `ser_in` fill).

## Test plan
- Reset, then load 0xA5 (WIDTH=8) → codes 10/01 pattern in LOAD cycle, `q`=0xA5 next edge, `done` pulse one cycle later.
- `q`=0x81, shift left count 3, `ser_in`=1 → `q` 0x03, 0x07, 0x0F; `ser_out` 1,0,0; `done` after 3rd shift.
- `q`=0x81, shift right count 2, `ser_in`=0 → `q` 0x40, 0x20; `ser_out` 1,0.
- Rotate left count 4 on 0x81 → 0x18 with macro; 0x10 (ser_in=0) without.
- Shift count 0 → `done` next cycle, `j`=`k`=0 throughout, `q` unchanged; `cmd_valid` held during busy not accepted.
- Assert `rst` mid-shift of count 10 → `j`=`k`=0 and `busy`=0 same cycle, no `done`, `cmd_ready`=1.

Source files
------------

// File: rtl/jk_shift_ctrl.sv
// jk_shift_ctrl: accepts load/shift/rotate commands and drives per-stage JK codes into a JK shift-register bank.
// Optional feature: define JK_SHIFT_CTRL_ROTATE_EN to make op 11 rotate left (otherwise op 11 acts as shift left).
module jk_shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_ROL = 2'b11} op_t;

   state_t           state, state_nx;
   op_t              op_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] target;
   logic             drive;
   logic             accept;

   assign cmd_ready = (state == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // NOTE: the command registers are reset as well; they are few flops and a reset keeps outputs X-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_LOAD;
         data_q <= '0;
         cnt_q  <= '0;
      end else if (accept) begin
         op_q   <= op_t'(cmd_op);
         data_q <= cmd_data;
         cnt_q  <= cmd_count;
      end else if (state == S_SHIFT) begin
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op_t'(cmd_op) == OP_LOAD) state_nx = S_LOAD;
               else if (cmd_count != '0)     state_nx = S_SHIFT;
               else                          state_nx = S_DONE;
            end
         end
         S_LOAD:  state_nx = S_DONE;
         S_SHIFT: if (cnt_q == CNT_W'(1)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Value each stage should take at the next edge; only meaningful while drive is high.
   always_comb begin
      target  = q;
      drive   = 1'b0;
      ser_out = 1'b0;
      case (state)
         S_LOAD: begin
            target = data_q;
            drive  = 1'b1;
         end
         S_SHIFT: begin
            drive = 1'b1;
            case (op_q)
               OP_SHR: begin
                  target  = {ser_in, q[WIDTH-1:1]};
                  ser_out = q[0];
               end
               OP_ROL: begin
`ifdef JK_SHIFT_CTRL_ROTATE_EN
                  target  = {q[WIDTH-2:0], q[WIDTH-1]};
`else
                  target  = {q[WIDTH-2:0], ser_in};
`endif
                  ser_out = q[WIDTH-1];
               end
               default: begin
                  target  = {q[WIDTH-2:0], ser_in};
                  ser_out = q[WIDTH-1];
               end
            endcase
         end
         default: ;
      endcase
   end

   // Code 01 sets a stage, 10 clears it; toggle (11) is never produced.
   assign j = drive ? ~target : '0;
   assign k = drive ?  target : '0;

endmodule
